// File: rtl/hash_clk_ramp_if.sv
// Control and status bundle for the soft-start hashing-core clock generator.
// The master drives start/stop/target_div; the slave returns the clock and ramp status.
interface hash_clk_ramp_if #(
  parameter int DW = 8
);
  logic          start;
  logic          stop;
  logic [DW-1:0] target_div;
  logic          core_clk;
  logic          core_ce;
  logic [DW-1:0] cur_div;
  logic          locked;
  logic          busy;

  modport master (
    output start, stop, target_div,
    input  core_clk, core_ce, cur_div, locked, busy
  );

  modport slave (
    input  start, stop, target_div,
    output core_clk, core_ce, cur_div, locked, busy
  );
endinterface

// File: rtl/hash_clk_ramp.sv
// Soft-start clock generator: divides osc_clk by a ratio that steps between DIV_MAX
// and a clamped target, one step per STEP_PERIODS whole core_clk periods.
module hash_clk_ramp #(
  parameter int DW           = 8,
  parameter int DIV_MAX      = 64,
  parameter int DIV_MIN      = 2,
  parameter int STEP_PERIODS = 16
) (
  input  logic           osc_clk,
  input  logic           reset,
  hash_clk_ramp_if.slave bus
);

  localparam int SW = $clog2(STEP_PERIODS + 1);
  localparam logic [DW-1:0] DIV_MAX_V = DW'(DIV_MAX);
  localparam logic [DW-1:0] DIV_MIN_V = DW'(DIV_MIN);
  localparam logic [SW-1:0] STEP_V    = SW'(STEP_PERIODS);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    RUN       = 2'd2,
    RAMP_DOWN = 2'd3
  } state_t;

  state_t        state_r, state_s;
  logic [DW-1:0] cnt_r, cnt_s;
  logic [DW-1:0] cur_div_r, cur_div_s;
  logic [DW-1:0] tgt_r, tgt_s;
  logic [SW-1:0] step_r, step_s;
  logic          core_clk_r, core_clk_s;
  logic          core_ce_r, core_ce_s;
  logic          locked_r, busy_r;
  logic          period_end_s;
  logic [SW-1:0] step_inc_s;
  logic          step_due_s;
  logic          start_ok_s;
  logic [DW-1:0] ramp_div_s;

  function automatic logic [DW-1:0] clamp_div(input logic [DW-1:0] d);
    if (d < DIV_MIN_V) begin
      clamp_div = DIV_MIN_V;
    end else if (d > DIV_MAX_V) begin
      clamp_div = DIV_MAX_V;
    end else begin
      clamp_div = d;
    end
  endfunction

  // Next-state, ratio stepping and next-cycle output decode
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    cur_div_s    = cur_div_r;
    tgt_s        = tgt_r;
    step_s       = step_r;
    period_end_s = (state_r != IDLE) && (cnt_r == (cur_div_r - 1'b1));
    step_inc_s   = (step_r >= STEP_V) ? STEP_V : (step_r + 1'b1);
    step_due_s   = (step_inc_s == STEP_V);
    start_ok_s   = bus.start && !bus.stop;
    if (cur_div_r > tgt_r) begin
      ramp_div_s = cur_div_r - 1'b1;
    end else if (cur_div_r < tgt_r) begin
      ramp_div_s = cur_div_r + 1'b1;
    end else begin
      ramp_div_s = cur_div_r;
    end

    if (state_r != IDLE) begin
      cnt_s  = period_end_s ? {DW{1'b0}} : (cnt_r + 1'b1);
      step_s = period_end_s ? step_inc_s : step_r;
    end else begin
      cnt_s  = {DW{1'b0}};
      step_s = step_r;
    end

    case (state_r)
      IDLE: begin
        if (start_ok_s) begin
          state_s = RAMP_UP;
          tgt_s   = clamp_div(bus.target_div);
          step_s  = {SW{1'b0}};
        end else begin
          state_s = IDLE;
        end
      end
      RAMP_UP: begin
        if (bus.stop) begin
          state_s = RAMP_DOWN;
        end else if (period_end_s && step_due_s && (cur_div_r != tgt_r)) begin
          cur_div_s = ramp_div_s;
          step_s    = {SW{1'b0}};
          state_s   = (ramp_div_s == tgt_r) ? RUN : RAMP_UP;
        end else if (period_end_s && (cur_div_r == tgt_r)) begin
          state_s = RUN;
        end else begin
          state_s = RAMP_UP;
        end
      end
      RUN: begin
        // Clearing the step count gives the first ramp-down ratio its full dwell.
        if (bus.stop) begin
          state_s = RAMP_DOWN;
          step_s  = {SW{1'b0}};
        end else begin
          state_s = RUN;
        end
      end
      RAMP_DOWN: begin
        if (start_ok_s) begin
          state_s = RAMP_UP;
          tgt_s   = clamp_div(bus.target_div);
        end else if (period_end_s && step_due_s) begin
          step_s = {SW{1'b0}};
          if (cur_div_r >= DIV_MAX_V) begin
            state_s = IDLE;
            cnt_s   = {DW{1'b0}};
          end else begin
            cur_div_s = cur_div_r + 1'b1;
          end
        end else begin
          state_s = RAMP_DOWN;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = {DW{1'b0}};
      end
    endcase

    core_clk_s = (state_s != IDLE) && (cnt_s < (cur_div_s >> 1'b1));
    core_ce_s  = (state_s != IDLE) && (cnt_s == (cur_div_s - 1'b1));
  end

  // State, counters and registered outputs
  always_ff @(posedge osc_clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      cnt_r      <= {DW{1'b0}};
      cur_div_r  <= DIV_MAX_V;
      tgt_r      <= DIV_MAX_V;
      step_r     <= {SW{1'b0}};
      core_clk_r <= 1'b0;
      core_ce_r  <= 1'b0;
      locked_r   <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      cur_div_r  <= cur_div_s;
      tgt_r      <= tgt_s;
      step_r     <= step_s;
      core_clk_r <= core_clk_s;
      core_ce_r  <= core_ce_s;
      locked_r   <= (state_s == RUN);
      busy_r     <= (state_s != IDLE);
    end
  end

  assign bus.core_clk = core_clk_r;
  assign bus.core_ce  = core_ce_r;
  assign bus.cur_div  = cur_div_r;
  assign bus.locked   = locked_r;
  assign bus.busy     = busy_r;

endmodule

// File: tb/tb_hash_clk_ramp.sv
// Directed bench for hash_clk_ramp with DIV_MAX=8, DIV_MIN=2, STEP_PERIODS=2;
// period lengths and high times are logged per core_ce and compared to hand-computed lists.
module tb_hash_clk_ramp;

  localparam int DW = 8;

  logic osc_clk = 1'b0;
  logic reset   = 1'b1;

  hash_clk_ramp_if #(.DW(DW)) bus ();

  hash_clk_ramp #(
    .DW(DW), .DIV_MAX(8), .DIV_MIN(2), .STEP_PERIODS(2)
  ) dut (
    .osc_clk(osc_clk),
    .reset  (reset),
    .bus    (bus)
  );

  always #5 osc_clk = ~osc_clk;

  int tests_run    = 0;
  int tests_failed = 0;
  int len_q[$];
  int hi_q[$];
  int exp_q[$];
  int run_len = 0;
  int run_hi  = 0;

  // Log the length and high time of every completed core_clk period
  always @(negedge osc_clk) begin
    if (reset || !bus.busy) begin
      run_len <= 0;
      run_hi  <= 0;
    end else if (bus.core_ce) begin
      len_q.push_back(run_len + 1);
      hi_q.push_back(run_hi + int'(bus.core_clk));
      run_len <= 0;
      run_hi  <= 0;
    end else begin
      run_len <= run_len + 1;
      run_hi  <= run_hi + int'(bus.core_clk);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_seq(input string tag, input int act[$], input int exp[$]);
    check({tag, "_count"}, act.size(), exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      if (i < act.size()) check($sformatf("%s_%0d", tag, i), act[i], exp[i]);
    end
  endtask

  task automatic pulse_start(input logic [DW-1:0] t);
    bus.target_div = t;
    bus.start      = 1'b1;
    @(negedge osc_clk);
    bus.start      = 1'b0;
    bus.target_div = 8'd3;
  endtask

  task automatic pulse_stop(input string tag);
    bus.stop = 1'b1;
    @(negedge osc_clk);
    bus.stop = 1'b0;
    check({tag, "_locked_after_stop"}, bus.locked, 1'b0);
    check({tag, "_busy_after_stop"}, bus.busy, 1'b1);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (bus.busy && n < budget) begin
      @(negedge osc_clk);
      n++;
    end
    check({tag, "_idle"}, bus.busy, 1'b0);
  endtask

  task automatic wait_locked(input string tag, input int budget);
    int n = 0;
    while (!bus.locked && n < budget) begin
      @(negedge osc_clk);
      n++;
    end
    check({tag, "_locked"}, bus.locked, 1'b1);
  endtask

  task automatic wait_div(input string tag, input int d, input int budget);
    int n = 0;
    while (int'(bus.cur_div) != d && n < budget) begin
      @(negedge osc_clk);
      n++;
    end
    check({tag, "_reach_div"}, bus.cur_div, d);
  endtask

  task automatic ramp_up_to_4(input string tag);
    len_q.delete();
    hi_q.delete();
    pulse_start(8'd4);
    check({tag, "_busy"}, bus.busy, 1'b1);
    check({tag, "_clk_first_rise"}, bus.core_clk, 1'b1);
    repeat (51) @(negedge osc_clk);
    check({tag, "_locked_c51"}, bus.locked, 1'b0);
    @(negedge osc_clk);
    check({tag, "_locked_c52"}, bus.locked, 1'b1);
    check({tag, "_div_run"}, bus.cur_div, 8'd4);
    repeat (8) @(negedge osc_clk);
    exp_q = '{8, 8, 7, 7, 6, 6, 5, 5, 4, 4};
    check_seq({tag, "_len"}, len_q, exp_q);
    exp_q = '{4, 4, 3, 3, 3, 3, 2, 2, 2, 2};
    check_seq({tag, "_hi"}, hi_q, exp_q);
  endtask

  initial begin
    bus.start      = 1'b0;
    bus.stop       = 1'b0;
    bus.target_div = 8'd0;
    repeat (3) @(negedge osc_clk);
    check("rst_core_clk", bus.core_clk, 1'b0);
    check("rst_core_ce", bus.core_ce, 1'b0);
    check("rst_locked", bus.locked, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_cur_div", bus.cur_div, 8'd8);
    reset = 1'b0;
    repeat (2) @(negedge osc_clk);

    // 1: ramp up from 8 to target 4
    ramp_up_to_4("t1");

    // 2: stop from RUN, issued at the start of a period
    begin
      int n = 0;
      while (!bus.core_ce && n < 10) begin
        @(negedge osc_clk);
        n++;
      end
      check("t2_sync_ce", bus.core_ce, 1'b1);
    end
    @(negedge osc_clk);
    len_q.delete();
    hi_q.delete();
    pulse_stop("t2");
    wait_idle("t2", 200);
    check("t2_clk_low", bus.core_clk, 1'b0);
    check("t2_div_max", bus.cur_div, 8'd8);
    exp_q = '{4, 4, 5, 5, 6, 6, 7, 7, 8, 8};
    check_seq("t2_len", len_q, exp_q);
    exp_q = '{2, 2, 2, 2, 3, 3, 3, 3, 4, 4};
    check_seq("t2_hi", hi_q, exp_q);

    // 3: target clamping below DIV_MIN and above DIV_MAX
    len_q.delete();
    pulse_start(8'd1);
    wait_locked("t3a", 200);
    check("t3a_div_clamped", bus.cur_div, 8'd2);
    exp_q = '{8, 8, 7, 7, 6, 6, 5, 5, 4, 4, 3, 3};
    check_seq("t3a_len", len_q, exp_q);
    len_q.delete();
    hi_q.delete();
    repeat (4) @(negedge osc_clk);
    exp_q = '{2, 2};
    check_seq("t3a_run_len", len_q, exp_q);
    exp_q = '{1, 1};
    check_seq("t3a_run_hi", hi_q, exp_q);
    pulse_stop("t3a");
    wait_idle("t3a", 300);
    len_q.delete();
    pulse_start(8'hFF);
    repeat (7) @(negedge osc_clk);
    check("t3b_locked_c7", bus.locked, 1'b0);
    @(negedge osc_clk);
    check("t3b_locked_c8", bus.locked, 1'b1);
    check("t3b_div", bus.cur_div, 8'd8);
    exp_q = '{8};
    check_seq("t3b_len", len_q, exp_q);
    pulse_stop("t3b");
    wait_idle("t3b", 100);

    // 4: stop during RAMP_UP right as the ratio reaches 6
    pulse_start(8'd2);
    wait_div("t4", 6, 100);
    len_q.delete();
    hi_q.delete();
    pulse_stop("t4");
    wait_idle("t4", 200);
    exp_q = '{6, 6, 7, 7, 8, 8};
    check_seq("t4_len", len_q, exp_q);
    exp_q = '{3, 3, 3, 3, 4, 4};
    check_seq("t4_hi", hi_q, exp_q);

    // 5a: start and stop together in RAMP_UP, stop must win
    len_q.delete();
    pulse_start(8'd4);
    repeat (10) @(negedge osc_clk);
    bus.start      = 1'b1;
    bus.stop       = 1'b1;
    bus.target_div = 8'd2;
    @(negedge osc_clk);
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    check("t5a_busy", bus.busy, 1'b1);
    wait_idle("t5a", 100);
    exp_q = '{8, 8};
    check_seq("t5a_len", len_q, exp_q);
    check("t5a_div", bus.cur_div, 8'd8);

    // 5b: start while in RUN is ignored
    pulse_start(8'd4);
    wait_locked("t5b", 100);
    pulse_start(8'd2);
    repeat (20) @(negedge osc_clk);
    check("t5b_div_held", bus.cur_div, 8'd4);
    check("t5b_still_locked", bus.locked, 1'b1);

    // 6: asynchronous reset mid-period while running, then restart
    pulse_stop("t6pre");
    wait_idle("t6pre", 200);
    pulse_start(8'd4);
    wait_locked("t6", 100);
    check("t6_clk_high_before", bus.core_clk, 1'b1);
    reset = 1'b1;
    #1;
    check("t6_rst_clk", bus.core_clk, 1'b0);
    check("t6_rst_ce", bus.core_ce, 1'b0);
    check("t6_rst_locked", bus.locked, 1'b0);
    check("t6_rst_busy", bus.busy, 1'b0);
    check("t6_rst_div", bus.cur_div, 8'd8);
    @(negedge osc_clk);
    reset = 1'b0;
    @(negedge osc_clk);
    ramp_up_to_4("t6r");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
